// File: rtl/dma_priority_arbiter_if.sv
// DMA arbiter bus: requests/controls in, resolved request and status out.
// master = register/TCL side, slave = arbiter; NUM_CH sets the widths.
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] DREQ;
  logic              DreqSense;
  logic [NUM_CH-1:0] Mask;
  logic [NUM_CH-1:0] SwReq;
  logic              Enable;
  logic              RotPri;
  logic              Accept;
  logic              ServiceDone;
  logic              ValidReqID;
  logic [ID_W-1:0]   ReqID;
  logic [NUM_CH-1:0] ReqStatus;
  logic              Busy;

  modport master (
    output DREQ, DreqSense, Mask, SwReq,
    output Enable, RotPri, Accept, ServiceDone,
    input  ValidReqID, ReqID, ReqStatus, Busy
  );

  modport slave (
    input  DREQ, DreqSense, Mask, SwReq,
    input  Enable, RotPri, Accept, ServiceDone,
    output ValidReqID, ReqID, ReqStatus, Busy
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA request arbiter: CLK, RESET_N (async, low), MasterClear, bus (slave).
// Rotating priority is compiled in only when DMA_ROTPRI_EN is defined.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input logic                   CLK,
  input logic                   RESET_N,
  input logic                   MasterClear,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERV
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_eff;
  logic [NUM_CH-1:0] w_eff;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_hp;
  logic              w_any;
  logic              r_valid;
  logic              r_busy;

  assign w_eff = ((bus.DREQ ~^ {NUM_CH{bus.DreqSense}})
                 | bus.SwReq) & ~bus.Mask;
  assign w_any = |r_eff;

  // Scan from the farthest slot back toward hp so the
  // nearest set request (from hp upward, wrapping) wins.
  always_comb begin
    int              j;
    logic [ID_W-1:0] w_idx;
    j     = 0;
    w_idx = '0;
    w_win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = int'(w_hp) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      w_idx = ID_W'(j);
      if (r_eff[w_idx]) w_win = w_idx;
    end
  end

`ifdef DMA_ROTPRI_EN
  logic [ID_W-1:0] r_hp;

  assign w_hp = r_hp;

  // The serviced channel drops to lowest priority.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hp <= '0;
    end else if (MasterClear || !bus.RotPri) begin
      r_hp <= '0;
    end else if (r_state == S_SERV && bus.ServiceDone) begin
      r_hp <= (r_id == ID_W'(NUM_CH - 1)) ? '0 : r_id + 1'b1;
    end
  end
`else
  logic w_unused_rotpri;

  assign w_hp            = '0;
  assign w_unused_rotpri = bus.RotPri;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_eff   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (MasterClear) begin
      r_state <= S_IDLE;
      r_eff   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_eff <= w_eff;
      unique case (r_state)
        S_IDLE: begin
          if (bus.Enable && w_any) begin
            r_id    <= w_win;
            r_valid <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus.Enable || !w_any) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Accept freezes whatever wins this same cycle.
            r_id <= w_win;
            if (bus.Accept) begin
              r_busy  <= 1'b1;
              r_state <= S_SERV;
            end
          end
        end
        S_SERV: begin
          if (bus.ServiceDone) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ValidReqID = r_valid;
  assign bus.ReqID      = r_id;
  assign bus.ReqStatus  = r_eff;
  assign bus.Busy       = r_busy;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: 4- and 5-channel instances,
// vector table for static arbitration plus multi-cycle sequences.
module tb_dma_priority_arbiter;

  logic CLK = 1'b0;
  logic RESET_N;
  logic MasterClear;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  dma_priority_arbiter_if #(.NUM_CH(4)) b4 ();
  dma_priority_arbiter_if #(.NUM_CH(5)) b5 ();

  dma_priority_arbiter #(.NUM_CH(4)) u4 (
    .CLK(CLK), .RESET_N(RESET_N),
    .MasterClear(MasterClear), .bus(b4)
  );

  dma_priority_arbiter #(.NUM_CH(5)) u5 (
    .CLK(CLK), .RESET_N(RESET_N),
    .MasterClear(MasterClear), .bus(b5)
  );

  typedef struct {
    logic [3:0] dreq;
    logic       sense;
    logic [3:0] mask;
    logic [3:0] sw;
    logic [3:0] st;
    logic       vld;
    int         id;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic accept4();
    b4.Accept = 1'b1;
    tick();
    b4.Accept = 1'b0;
  endtask

  task automatic done4();
    b4.ServiceDone = 1'b1;
    tick();
    b4.ServiceDone = 1'b0;
  endtask

  task automatic outs0(input string nm);
    chk({nm, "_vld"}, int'(b4.ValidReqID), 0);
    chk({nm, "_id"}, int'(b4.ReqID), 0);
    chk({nm, "_st"}, int'(b4.ReqStatus), 0);
    chk({nm, "_busy"}, int'(b4.Busy), 0);
  endtask

  initial begin
    vt[0] = '{4'b1010, 1'b1, 4'b0000, 4'b0000, 4'b1010, 1'b1, 1};
    vt[1] = '{4'b1110, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 0};
    vt[2] = '{4'b1110, 1'b0, 4'b0001, 4'b1000, 4'b1000, 1'b1, 3};
    vt[3] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
    vt[4] = '{4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2};
    vt[5] = '{4'b1100, 1'b1, 4'b0100, 4'b0000, 4'b1000, 1'b1, 3};
    vt[6] = '{4'b0000, 1'b1, 4'b0000, 4'b0110, 4'b0110, 1'b1, 1};
    vt[7] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 0};

    RESET_N        = 1'b0;
    MasterClear    = 1'b0;
    b4.DREQ        = '0;
    b4.DreqSense   = 1'b1;
    b4.Mask        = '0;
    b4.SwReq       = '0;
    b4.Enable      = 1'b1;
    b4.RotPri      = 1'b0;
    b4.Accept      = 1'b0;
    b4.ServiceDone = 1'b0;
    b5.DREQ        = '0;
    b5.DreqSense   = 1'b1;
    b5.Mask        = '0;
    b5.SwReq       = '0;
    b5.Enable      = 1'b1;
    b5.RotPri      = 1'b0;
    b5.Accept      = 1'b0;
    b5.ServiceDone = 1'b0;

    #12;
    outs0("reset");
    chk("reset_u5_vld", int'(b5.ValidReqID), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      b4.DREQ      = vt[i].dreq;
      b4.DreqSense = vt[i].sense;
      b4.Mask      = vt[i].mask;
      b4.SwReq     = vt[i].sw;
      tick();
      tick();
      chk($sformatf("vec%0d_st", i), int'(b4.ReqStatus), int'(vt[i].st));
      chk($sformatf("vec%0d_vld", i), int'(b4.ValidReqID), int'(vt[i].vld));
      if (vt[i].vld)
        chk($sformatf("vec%0d_id", i), int'(b4.ReqID), vt[i].id);
    end
    b4.Mask      = '0;
    b4.SwReq     = '0;
    b4.DreqSense = 1'b1;
    b4.DREQ      = '0;
    tick();
    tick();

    b4.DREQ = 4'b1010;
    tick();
    chk("lat1_vld", int'(b4.ValidReqID), 0);
    chk("lat1_st", int'(b4.ReqStatus), 4'b1010);
    tick();
    chk("fix_vld", int'(b4.ValidReqID), 1);
    chk("fix_id", int'(b4.ReqID), 1);
    accept4();
    chk("acc_busy", int'(b4.Busy), 1);
    b4.DREQ = 4'b1000;
    tick();
    tick();
    chk("svc_id", int'(b4.ReqID), 1);
    chk("svc_busy", int'(b4.Busy), 1);
    chk("svc_st", int'(b4.ReqStatus), 4'b1000);
    done4();
    chk("done_busy", int'(b4.Busy), 0);
    chk("done_vld", int'(b4.ValidReqID), 0);
    tick();
    chk("reoffer_vld", int'(b4.ValidReqID), 1);
    chk("reoffer_id", int'(b4.ReqID), 3);

    done4();
    chk("done_ign_vld", int'(b4.ValidReqID), 1);
    chk("done_ign_busy", int'(b4.Busy), 0);
    b4.DREQ = '0;
    tick();
    tick();
    chk("drop_vld", int'(b4.ValidReqID), 0);
    accept4();
    chk("acc_ign_busy", int'(b4.Busy), 0);
    chk("acc_ign_vld", int'(b4.ValidReqID), 0);

    b4.DREQ = 4'b0100;
    tick();
    tick();
    chk("pre_id2", int'(b4.ReqID), 2);
    b4.DREQ = 4'b0101;
    tick();
    chk("pre_hold", int'(b4.ReqID), 2);
    tick();
    chk("preempt", int'(b4.ReqID), 0);

    b4.DREQ = 4'b0100;
    tick();
    tick();
    chk("rearb_id2", int'(b4.ReqID), 2);
    b4.DREQ = 4'b0101;
    tick();
    accept4();
    chk("acc_rearb_id", int'(b4.ReqID), 0);
    chk("acc_rearb_busy", int'(b4.Busy), 1);
    b4.DREQ = 4'b0100;
    tick();
    tick();
    chk("acc_rearb_frz", int'(b4.ReqID), 0);
    done4();
    b4.DREQ = '0;
    tick();
    tick();
    tick();
    chk("idle_vld", int'(b4.ValidReqID), 0);

    b4.DREQ = 4'b0100;
    tick();
    tick();
    accept4();
    b4.DREQ = 4'b0101;
    tick();
    tick();
    tick();
    chk("frz_id", int'(b4.ReqID), 2);
    chk("frz_busy", int'(b4.Busy), 1);
    done4();
    chk("frz_done_vld", int'(b4.ValidReqID), 0);
    tick();
    chk("frz_next_vld", int'(b4.ValidReqID), 1);
    chk("frz_next_id", int'(b4.ReqID), 0);

    b4.Enable = 1'b0;
    tick();
    tick();
    tick();
    chk("en_off_vld", int'(b4.ValidReqID), 0);
    chk("en_off_st", int'(b4.ReqStatus), 4'b0101);
    b4.Enable = 1'b1;
    tick();
    chk("en_on_vld", int'(b4.ValidReqID), 1);
    chk("en_on_id", int'(b4.ReqID), 0);

    b4.DREQ = 4'b1000;
    tick();
    tick();
    chk("mc_pre_id", int'(b4.ReqID), 3);
    MasterClear = 1'b1;
    tick();
    MasterClear = 1'b0;
    outs0("mclr");
    b4.DREQ = '0;
    tick();
    tick();

    b4.RotPri = 1'b1;
    b4.DREQ   = 4'b1111;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
`ifdef DMA_ROTPRI_EN
      chk($sformatf("rot4_%0d", i), int'(b4.ReqID), i % 4);
`else
      chk($sformatf("rot4_%0d", i), int'(b4.ReqID), 0);
`endif
      chk($sformatf("rot4_vld%0d", i), int'(b4.ValidReqID), 1);
      accept4();
      done4();
      tick();
    end

    accept4();
    chk("rst_pre_busy", int'(b4.Busy), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    outs0("rst_async");
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    tick();
    chk("rst_hp_vld", int'(b4.ValidReqID), 1);
    chk("rst_hp_id", int'(b4.ReqID), 0);

    b5.RotPri = 1'b1;
    b5.DREQ   = 5'b11111;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
`ifdef DMA_ROTPRI_EN
      chk($sformatf("rot5_%0d", i), int'(b5.ReqID), i % 5);
`else
      chk($sformatf("rot5_%0d", i), int'(b5.ReqID), 0);
`endif
      b5.Accept = 1'b1;
      tick();
      b5.Accept = 1'b0;
      chk($sformatf("rot5_busy%0d", i), int'(b5.Busy), 1);
      b5.ServiceDone = 1'b1;
      tick();
      b5.ServiceDone = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Parametrised successor to the DMA request priority encoder: it resolves device and software DMA requests across `NUM_CH` channels and drives `ValidReqID`/`ReqID` into the timing control logic. It adds configurable request polarity, masking, software requests, rotating priority, and a service handshake that freezes the winner until the transfer ends. It sits between the device `DREQ` pins, the command/mask/request registers, and the TCL.

## Interface
- `NUM_CH`, default 4: number of channels, legal range 2..16, not required to be a power of two.
- `ID_W`, default `$clog2(NUM_CH)`: channel ID width. It is derived and must not be overridden.

Ports:
- `CLK`, input, 1: single clock. All state is updated on its rising edge.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `MasterClear`, input, 1: synchronous clear. Same effect as reset.
- `DREQ`, input, `NUM_CH`: raw device requests.
- `DreqSense`, input, 1: 1 means `DREQ` is active-high, 0 means active-low.
- `Mask`, input, `NUM_CH`: 1 masks that channel's hardware and software request.
- `SwReq`, input, `NUM_CH`: software request bits from the request register.
- `Enable`, input, 1: controller enable. 0 blocks new grants.
- `RotPri`, input, 1: 1 selects rotating priority, 0 selects fixed priority.
- `Accept`, input, 1: TCL has taken the offered request (HLDA received).
- `ServiceDone`, input, 1: single-cycle pulse from TCL when service ends (TC, EOP, or demand drop).
- `ValidReqID`, output, 1: a resolved request is offered or in service.
- `ReqID`, output, `ID_W`: winning channel.
- `ReqStatus`, output, `NUM_CH`: registered effective requests, used for status register bits.
- `Busy`, output, 1: a channel is in service.

## Operation
- Sample stage: `eff[i]` is registered every cycle.
  - `eff[i] = ((DREQ[i] ~^ DreqSense) | SwReq[i]) & ~Mask[i]`.
  - `ReqStatus = eff`.
- Priority pointer `hp` (`ID_W` bits) names the highest-priority channel. It resets to 0.
- Search order is `hp`, `hp+1`, … with wrap from `NUM_CH-1` to 0. The first set `eff` bit wins.
- The state machine has three states:
  - **IDLE**:
    - `ValidReqID = 0`.
    - If `Enable` and any `eff` bit is set, register the winner into `ReqID` and go to REQ.
  - **REQ**:
    - `ValidReqID = 1`.
    - Re-arbitrate every cycle. A newly arrived higher-priority request replaces `ReqID`.
    - If `eff` becomes all-zero or `Enable` goes to 0, go to IDLE.
    - If `Accept` = 1, freeze `ReqID` and go to SERVICE.
  - **SERVICE**:
    - `ValidReqID = 1`, `Busy = 1`, and `ReqID` is frozen.
    - Mask, `DREQ`, and `Enable` changes are ignored.
    - `ServiceDone` returns the state machine to IDLE.
    - With `RotPri = 1`, `hp` is updated to `(ReqID+1) mod NUM_CH`, so the serviced channel becomes lowest priority.
- `RotPri = 0` holds `hp` at 0 (fixed priority, channel 0 highest). Switching to rotating priority starts from `hp = 0`.
- Simultaneous events:
  - `Accept` and a re-arbitration in the same REQ cycle: the newly selected ID is the one frozen.
  - `ServiceDone` outside SERVICE and `Accept` outside REQ are ignored.
  - `ServiceDone` and a new request in the same cycle: go to IDLE, then re-offer the request on the next cycle.
- `SwReq` bits are not cleared here. The datapath clears them on TC.

## Timing
- Reset (`RESET_N` low, asynchronous) or `MasterClear` (synchronous) puts the block in this state:
  - Outputs: `ValidReqID = 0`, `ReqID = 0`, `ReqStatus = 0`, `Busy = 0`.
  - Internal state: IDLE, `hp = 0`.
- Reset or clear during SERVICE aborts the service immediately. No `hp` update occurs.
- Latency from a request edge to outputs:
  - Edge (sampled at edge N) → `ReqStatus` at N+1.
  - `ValidReqID`/`ReqID` at N+2.
- `Accept` at edge M (in REQ) → `Busy = 1` from M+1.
- `ServiceDone` at edge K → `Busy = 0`, `ValidReqID = 0`, and the `hp` update all appear at K+1.
- The earliest re-offer is K+2.

## Configuration
- `DMA_ROTPRI_EN` defined: rotating priority logic is compiled in and `RotPri` behaves as above.
- `DMA_ROTPRI_EN` undefined: the `hp` register and rotation logic are removed.
  - `RotPri` is ignored.
  - Priority is fixed, with channel 0 highest.
  - The port list is unchanged.

## Test plan
- Fixed priority:
  - Stimulus: `NUM_CH=4`, `DreqSense=1`, `RotPri=0`, `DREQ=4'b1010`.
  - Required response: `ReqID=1`, `ValidReqID=1` two cycles later.
  - After `Accept` then `ServiceDone`, with `DREQ[1]` dropped: `ReqID=3`.
- Rotation:
  - Stimulus: `RotPri=1`, `DREQ=4'b1111` held, accept/done loop.
  - Required response: `ReqID` sequence 0, 1, 2, 3, 0.
  - Stimulus: `NUM_CH=5`.
  - Required response: sequence 0, 1, 2, 3, 4, 0 (wrap).
- Preempt and freeze:
  - Stimulus: `DREQ[2]` asserted, then `DREQ[0]` asserted while in REQ.
  - Required response: `ReqID` changes 2→0.
  - Stimulus: the same order while in SERVICE.
  - Required response: `ReqID` stays 2 until `ServiceDone`.
- Polarity, mask, and software request:
  - Stimulus: `DreqSense=0`, `DREQ=4'b1110`.
  - Required response: `ReqID=0`.
  - Stimulus: `Mask=4'b0001`, `SwReq=4'b1000`.
  - Required response: `ReqID=3`, `ReqStatus=4'b1000`.
- Enable, reset, and clear:
  - Stimulus: `Enable=0` with requests pending.
  - Required response: `ValidReqID` stays 0.
  - Stimulus: `RESET_N` pulsed low mid-SERVICE.
  - Required response: all outputs 0 asynchronously and `hp=0`.
  - Stimulus: `MasterClear` asserted.
  - Required response: the same state at the next edge.
